dc_token_ring_tx: RTL and testbench



---
 rtl/dc_token_ring_tx.sv | 76 +++++++
 tb/tb_dc_token_ring_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_token_ring_tx.sv
// Source half of the token-ring CDC FIFO: register buffer written at a one-hot
// token, throttled against the synchronized one-hot read pointer of the receiver.
module dc_token_ring_tx #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [DATA_WIDTH-1:0]              data_i,
    output logic [BUFFER_DEPTH-1:0]            write_token_o,
    input  logic [BUFFER_DEPTH-1:0]            read_pointer_i,
    output logic [DATA_WIDTH*BUFFER_DEPTH-1:0] data_async_o
);

    localparam logic [BUFFER_DEPTH-1:0] SLOT0 = BUFFER_DEPTH'(1);

    logic [BUFFER_DEPTH-1:0] write_token_q, write_token_d;
    logic [BUFFER_DEPTH-1:0] token_next;
    logic [BUFFER_DEPTH-1:0] rp_meta_q, rp_sync_q;
    logic [DATA_WIDTH-1:0]   buffer_q [BUFFER_DEPTH];
    logic                    full;
    logic                    accept;

    assign token_next = {write_token_q[BUFFER_DEPTH-2:0], write_token_q[BUFFER_DEPTH-1]};

    // An all-zero or multi-hot sampled pointer can only ever make this more
    // conservative, so synchronizer transients never let a live slot be hit.
    assign full    = (rp_sync_q == '0) || ((token_next & rp_sync_q) != '0);
    assign ready_o = ~full;
    assign accept  = valid_i & ~full;

    always_comb begin
        write_token_d = write_token_q;
        if (accept) begin
            write_token_d = token_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_token_q <= SLOT0;
            rp_meta_q     <= SLOT0;
            rp_sync_q     <= SLOT0;
        end else begin
            write_token_q <= write_token_d;
            rp_meta_q     <= read_pointer_i;
            rp_sync_q     <= rp_meta_q;
        end
    end

    for (genvar k = 0; k < BUFFER_DEPTH; k++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_d;

        always_comb begin
            slot_d = buffer_q[k];
            if (accept && write_token_q[k]) begin
                slot_d = data_i;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                buffer_q[k] <= '0;
            end else begin
                buffer_q[k] <= slot_d;
            end
        end

        assign data_async_o[k*DATA_WIDTH +: DATA_WIDTH] = buffer_q[k];
    end

    assign write_token_o = write_token_q;

endmodule

// File: tb/tb_dc_token_ring_tx.sv
// Directed bench for dc_token_ring_tx: reset, fill, release, bad pointers,
// mid-stream reset and a randomized receiver with an in-order scoreboard.
module tb_dc_token_ring_tx;

    localparam int DW = 32;
    localparam int BD = 8;

    logic             clk_i;
    logic             rst_ni;
    logic             valid_i;
    logic             ready_o;
    logic [DW-1:0]    data_i;
    logic [BD-1:0]    write_token_o;
    logic [BD-1:0]    read_pointer_i;
    logic [DW*BD-1:0] data_async_o;

    int n_checks;
    int n_fail;

    dc_token_ring_tx #(.DATA_WIDTH(DW), .BUFFER_DEPTH(BD)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_i         (data_i),
        .write_token_o  (write_token_o),
        .read_pointer_i (read_pointer_i),
        .data_async_o   (data_async_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni         = 1'b0;
        valid_i        = 1'b0;
        read_pointer_i = 8'h01;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni         = 1'b0;
        valid_i        = 1'b1;
        data_i         = 32'hDEAD_BEEF;
        read_pointer_i = 8'h01;
        repeat (4) @(negedge clk_i);
        n_checks++;
        if (write_token_o !== 8'h01) begin
            n_fail++; $display("FAIL reset_token: got %h want 01", write_token_o);
        end
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o);
        end
        n_checks++;
        if (data_async_o !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", data_async_o);
        end
        valid_i = 1'b0;
        rst_ni  = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (write_token_o !== 8'h01 || data_async_o !== '0) begin
            n_fail++; $display("FAIL reset_no_accept: token %h data %h want 01 / 0", write_token_o, data_async_o);
        end
    endtask

    task automatic fill(input logic [7:0] base, output int acc);
        acc     = 0;
        valid_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            data_i = {24'h0, base + 8'(acc)};
            if (ready_o) acc++;
            @(negedge clk_i);
        end
        data_i = {24'h0, base + 8'(acc)};
    endtask

    task automatic test_fill();
        int acc;
        fill(8'hA0, acc);
        n_checks++;
        if (acc !== 7) begin
            n_fail++; $display("FAIL fill_count: got %0d want 7", acc);
        end
        n_checks++;
        if (write_token_o !== 8'h80) begin
            n_fail++; $display("FAIL fill_token: got %h want 80", write_token_o);
        end
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++; $display("FAIL fill_ready: got %b want 0", ready_o);
        end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (data_async_o[k*DW +: DW] !== 32'hA0 + 32'(k)) begin
                n_fail++; $display("FAIL fill_slot%0d: got %h want %h", k, data_async_o[k*DW +: DW], 32'hA0 + 32'(k));
            end
        end
        n_checks++;
        if (data_async_o[7*DW +: DW] !== 32'h0) begin
            n_fail++; $display("FAIL fill_slot7: got %h want 0", data_async_o[7*DW +: DW]);
        end
    endtask

    task automatic test_release();
        read_pointer_i = 8'h02;
        @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++; $display("FAIL release_edge1: got %b want 0", ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL release_edge2: got %b want 1", ready_o);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        n_checks++;
        if (data_async_o[7*DW +: DW] !== 32'hA7) begin
            n_fail++; $display("FAIL release_slot7: got %h want a7", data_async_o[7*DW +: DW]);
        end
        n_checks++;
        if (write_token_o !== 8'h01) begin
            n_fail++; $display("FAIL release_token: got %h want 01", write_token_o);
        end
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++; $display("FAIL release_refull: got %b want 0", ready_o);
        end
    endtask

    task automatic test_bad_pointer();
        do_reset();
        @(negedge clk_i);
        read_pointer_i = 8'h00;
        @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bad_zero_edge1: got %b want 1", ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bad_zero: got %b want 0", ready_o);
        end
        read_pointer_i = 8'h06;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bad_twohot_hit: got %b want 0", ready_o);
        end
        read_pointer_i = 8'h08;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bad_nohit: got %b want 1", ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        do_reset();
        @(negedge clk_i);
        acc     = 0;
        valid_i = 1'b1;
        while (acc < 3) begin
            data_i = 32'hB0 + 32'(acc);
            if (ready_o) acc++;
            @(negedge clk_i);
        end
        n_checks++;
        if (write_token_o !== 8'h08) begin
            n_fail++; $display("FAIL mid_pre_token: got %h want 08", write_token_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (write_token_o !== 8'h01 || ready_o !== 1'b1 || data_async_o !== '0) begin
            n_fail++; $display("FAIL mid_async_reset: token %h ready %b data %h want 01 1 0", write_token_o, ready_o, data_async_o);
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        fill(8'hC0, acc);
        valid_i = 1'b0;
        n_checks++;
        if (acc !== 7 || write_token_o !== 8'h80) begin
            n_fail++; $display("FAIL mid_refill: count %0d token %h want 7 80", acc, write_token_o);
        end
        n_checks++;
        if (data_async_o[6*DW +: DW] !== 32'hC6) begin
            n_fail++; $display("FAIL mid_refill_slot6: got %h want c6", data_async_o[6*DW +: DW]);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] q[$];
        int sent, rcvd, ri, cyc;
        do_reset();
        @(negedge clk_i);
        sent = 0; rcvd = 0; ri = 0; cyc = 0;
        while (rcvd < 50 && cyc < 2000) begin
            if (q.size() > 0 && ($urandom_range(0, 2) != 0)) begin
                n_checks++;
                if (data_async_o[ri*DW +: DW] !== q[0]) begin
                    n_fail++; $display("FAIL wrap_order beat %0d slot %0d: got %h want %h", rcvd, ri, data_async_o[ri*DW +: DW], q[0]);
                end
                void'(q.pop_front());
                rcvd++;
                ri = (ri + 1) % BD;
                read_pointer_i = 8'(1 << ri);
            end
            if (sent < 50) begin
                valid_i = 1'b1;
                data_i  = 32'h1000 + 32'(sent);
                if (ready_o) begin
                    n_checks++;
                    if (q.size() >= BD - 1) begin
                        n_fail++; $display("FAIL wrap_overrun: occupancy %0d want < 7", q.size());
                    end
                    q.push_back(data_i);
                    sent++;
                end
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        valid_i = 1'b0;
        n_checks++;
        if (rcvd !== 50) begin
            n_fail++; $display("FAIL wrap_timeout: received %0d want 50", rcvd);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_ni         = 1'b0;
        valid_i        = 1'b0;
        data_i         = '0;
        read_pointer_i = 8'h01;
        test_reset();
        test_fill();
        test_release();
        test_bad_pointer();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
